// File: rtl/uart_cal_pkg.sv
// Shared constants and types for the UART calculator command parser.
// Covers ASCII codes, opcode and error encodings, and the parser state type.
package uart_cal_pkg;

    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_9     = 8'h39;
    localparam logic [7:0] ASC_PLUS  = 8'h2B;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_MUL   = 8'h2A;
    localparam logic [7:0] ASC_DIV   = 8'h2F;
    localparam logic [7:0] ASC_EQ    = 8'h3D;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_SP    = 8'h20;
    localparam logic [7:0] ASC_ESC   = 8'h1B;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_OVF     = 2'b10;
    localparam logic [1:0] ERR_BUSY    = 2'b11;

    typedef enum logic [1:0] {
        S_A    = 2'b00,
        S_B    = 2'b01,
        S_OUT  = 2'b10,
        S_SKIP = 2'b11
    } state_t;

    // Returns {is_operator, opcode}.
    function automatic logic [2:0] decode_op(input logic [7:0] c);
        logic [2:0] res;
        case (c)
            ASC_PLUS:  res = {1'b1, OP_ADD};
            ASC_MINUS: res = {1'b1, OP_SUB};
            ASC_MUL:   res = {1'b1, OP_MUL};
            ASC_DIV:   res = {1'b1, OP_DIV};
            default:   res = 3'b000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/uart_dec_acc.sv
// Decimal accumulator: value <= value*10 + digit, with an overflow flag that
// reports whether loading the presented digit would exceed DATA_W bits.
module uart_dec_acc #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [3:0]        digit,
    output logic [DATA_W-1:0] value,
    output logic              ovf
);

    localparam int unsigned AccW = DATA_W + 4;

    logic [DATA_W-1:0] acc_q;
    logic [AccW-1:0]   acc_ext;
    logic [AccW-1:0]   next_val;

    // x*10 as x*8 + x*2; the 4 extra bits hold the worst case (2^W-1)*10+9.
    always_comb begin
        acc_ext  = {4'b0000, acc_q};
        next_val = (acc_ext << 3) + (acc_ext << 1) + {{DATA_W{1'b0}}, digit};
        ovf      = |next_val[AccW-1:DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc_q <= '0;
        end else if (load) begin
            acc_q <= next_val[DATA_W-1:0];
        end
    end

    assign value = acc_q;

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses "A<op>B=" ASCII commands from the UART receiver into operands and an opcode.
// Optional byte echo toward the transmitter is enabled by defining UART_ECHO_EN.
module uart_cmd_parser
    import uart_cal_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] operand_a,
    output logic [DATA_W-1:0] operand_b,
    output logic [1:0]        opcode,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [7:0]        echo_data,
    output logic              echo_valid
);

    state_t     state_q, state_d;
    logic       rx_valid_q;
    logic       a_seen_q, a_seen_d;
    logic       b_seen_q, b_seen_d;
    logic [1:0] opcode_q, opcode_d;
    logic       err_q, err_d;
    logic [1:0] err_code_q, err_code_d;

    logic       accept;
    logic       is_digit, is_term, is_esc, is_sp;
    logic [2:0] op_dec;
    logic [3:0] digit;
    logic       clear_acc, load_a, load_b;
    logic       ovf_a, ovf_b;

    // Accept exactly one byte per rx_valid rising edge.
    assign accept   = rx_valid & ~rx_valid_q;
    assign is_digit = (rx_data >= ASC_0) && (rx_data <= ASC_9);
    assign is_term  = (rx_data == ASC_EQ) || (rx_data == ASC_CR);
    assign is_esc   = (rx_data == ASC_ESC);
    assign is_sp    = (rx_data == ASC_SP);
    assign op_dec   = decode_op(rx_data);
    assign digit    = rx_data[3:0];

    uart_dec_acc #(.DATA_W(DATA_W)) u_acc_a (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_acc),
        .load  (load_a),
        .digit (digit),
        .value (operand_a),
        .ovf   (ovf_a)
    );

    uart_dec_acc #(.DATA_W(DATA_W)) u_acc_b (
        .clk   (clk),
        .rst   (rst),
        .clear (clear_acc),
        .load  (load_b),
        .digit (digit),
        .value (operand_b),
        .ovf   (ovf_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_A;
            rx_valid_q <= 1'b0;
            a_seen_q   <= 1'b0;
            b_seen_q   <= 1'b0;
            opcode_q   <= OP_ADD;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            rx_valid_q <= rx_valid;
            a_seen_q   <= a_seen_d;
            b_seen_q   <= b_seen_d;
            opcode_q   <= opcode_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_seen_d   = a_seen_q;
        b_seen_d   = b_seen_q;
        opcode_d   = opcode_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        clear_acc  = 1'b0;
        load_a     = 1'b0;
        load_b     = 1'b0;

        unique case (state_q)
            S_A: begin
                if (accept && !is_sp) begin
                    if (is_esc) begin
                        clear_acc = 1'b1;
                    end else if (is_digit) begin
                        if (ovf_a) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_OVF;
                            state_d    = S_SKIP;
                        end else begin
                            load_a   = 1'b1;
                            a_seen_d = 1'b1;
                        end
                    end else if (op_dec[2] && a_seen_q) begin
                        opcode_d = op_dec[1:0];
                        state_d  = S_B;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_ILLEGAL;
                        state_d    = S_SKIP;
                    end
                end
            end
            S_B: begin
                if (accept && !is_sp) begin
                    if (is_esc) begin
                        clear_acc = 1'b1;
                        state_d   = S_A;
                    end else if (is_digit) begin
                        if (ovf_b) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_OVF;
                            state_d    = S_SKIP;
                        end else begin
                            load_b   = 1'b1;
                            b_seen_d = 1'b1;
                        end
                    end else if (is_term && b_seen_q) begin
                        state_d = S_OUT;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_ILLEGAL;
                        state_d    = S_SKIP;
                    end
                end
            end
            S_OUT: begin
                // The pending command is never disturbed; stray bytes only flag busy.
                if (accept && !is_sp) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_BUSY;
                end
                if (cmd_ready) begin
                    clear_acc = 1'b1;
                    state_d   = S_A;
                end
            end
            S_SKIP: begin
                if (accept && (is_term || is_esc)) begin
                    clear_acc = 1'b1;
                    state_d   = S_A;
                end
            end
            default: state_d = S_A;
        endcase

        if (clear_acc) begin
            a_seen_d = 1'b0;
            b_seen_d = 1'b0;
        end
    end

    always_comb begin
        cmd_valid = (state_q == S_OUT);
    end

    assign opcode   = opcode_q;
    assign err      = err_q;
    assign err_code = err_code_q;

`ifdef UART_ECHO_EN
    logic [7:0] echo_data_q;
    logic       echo_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            echo_data_q  <= 8'h00;
            echo_valid_q <= 1'b0;
        end else begin
            echo_valid_q <= accept;
            if (accept) begin
                echo_data_q <= rx_data;
            end
        end
    end

    assign echo_data  = echo_data_q;
    assign echo_valid = echo_valid_q;
`else
    assign echo_data  = 8'h00;
    assign echo_valid = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: table vectors, hand sequences for
// back-pressure/busy/reset, and random traffic against a character-level model.
module tb_uart_cmd_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [15:0] operand_a, operand_b;
    logic [1:0]  opcode;
    logic        cmd_valid;
    logic        cmd_ready = 1'b1;
    logic        err;
    logic [1:0]  err_code;
    logic [7:0]  echo_data;
    logic        echo_valid;

    always #10 clk = ~clk;

    uart_cmd_parser #(.DATA_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .opcode     (opcode),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .err        (err),
        .err_code   (err_code),
        .echo_data  (echo_data),
        .echo_valid (echo_valid)
    );

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
    } cmd_t;

    typedef struct {
        string s;
        int    n_cmd;
        int    a;
        int    b;
        int    op;
        int    n_err;
        int    code;
    } vec_t;

    cmd_t       got_cmd[$];
    cmd_t       exp_cmd[$];
    logic [1:0] got_err[$];
    logic [1:0] exp_err[$];

    int checks = 0;
    int errors = 0;
    int pulse_bad = 0;
    int stab_bad = 0;
    int echo_bad = 0;

    logic        prev_err = 1'b0, prev_valid = 1'b0, prev_hs = 1'b0;
    logic [15:0] prev_a = '0, prev_b = '0;
    logic [1:0]  prev_op = '0;

    // Observe handshakes and error pulses away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_err   = 1'b0;
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) got_cmd.push_back({operand_a, operand_b, opcode});
            if (err) got_err.push_back(err_code);
            if (err && prev_err) pulse_bad++;
            if (cmd_valid && prev_valid && !prev_hs &&
                (operand_a != prev_a || operand_b != prev_b || opcode != prev_op)) stab_bad++;
`ifndef UART_ECHO_EN
            if (echo_valid || echo_data != 8'h00) echo_bad++;
`endif
            prev_err   = err;
            prev_valid = cmd_valid;
            prev_hs    = cmd_valid && cmd_ready;
            prev_a     = operand_a;
            prev_b     = operand_b;
            prev_op    = opcode;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Call at posedge+#1; returns at posedge+#1.
    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic send_str(input string s, input int hold);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], (hold > 0) ? hold : int'($urandom_range(1, 3)),
                      int'($urandom_range(1, 2)));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Character-level reference: modes 0 = reading A, 1 = reading B, 2 = discarding.
    int          m_mode;
    longint      m_a, m_b;
    bit          m_sa, m_sb;
    logic [1:0]  m_op;

    function automatic void model_clear();
        m_mode = 0;
        m_a    = 0;
        m_b    = 0;
        m_sa   = 0;
        m_sb   = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] c);
        bit         dig, term, esc, isop;
        longint     v;
        logic [1:0] op;
        dig  = (c >= 8'h30) && (c <= 8'h39);
        term = (c == 8'h3D) || (c == 8'h0D);
        esc  = (c == 8'h1B);
        isop = 1'b1;
        op   = 2'd0;
        case (c)
            8'h2B:   op = 2'd0;
            8'h2D:   op = 2'd1;
            8'h2A:   op = 2'd2;
            8'h2F:   op = 2'd3;
            default: isop = 1'b0;
        endcase
        if (m_mode == 2) begin
            if (term || esc) model_clear();
        end else if (c == 8'h20) begin
            // spaces never matter outside a pending command
        end else if (esc) begin
            model_clear();
        end else if (dig) begin
            v = ((m_mode == 0) ? m_a : m_b) * 10 + longint'(c) - 48;
            if (v > 65535) begin
                exp_err.push_back(2'b10);
                m_mode = 2;
            end else if (m_mode == 0) begin
                m_a  = v;
                m_sa = 1;
            end else begin
                m_b  = v;
                m_sb = 1;
            end
        end else if (m_mode == 0 && isop && m_sa) begin
            m_op   = op;
            m_mode = 1;
        end else if (m_mode == 1 && term && m_sb) begin
            exp_cmd.push_back({16'(m_a), 16'(m_b), m_op});
            model_clear();
        end else begin
            exp_err.push_back(2'b01);
            m_mode = 2;
        end
    endfunction

    function automatic vec_t mk(input string s, input int nc, input int a, input int b,
                                input int op, input int ne, input int code);
        vec_t v;
        v.s     = s;
        v.n_cmd = nc;
        v.a     = a;
        v.b     = b;
        v.op    = op;
        v.n_err = ne;
        v.code  = code;
        return v;
    endfunction

    vec_t       vecs[11];
    logic [7:0] pool[12];

    initial begin
        vecs[0]  = mk("12+34=",              1, 12,    34, 0, 0, 0);
        vecs[1]  = mk("65536+1=",            0, 0,     0,  0, 1, 2);
        vecs[2]  = mk("7/7=",                1, 7,     7,  3, 0, 0);
        vecs[3]  = mk("+5=",                 0, 0,     0,  0, 1, 1);
        vecs[4]  = mk("3x\0339-4=",          1, 9,     4,  1, 1, 1);
        vecs[5]  = mk(" 1 0 0 * 2 5 \015",   1, 100,   25, 2, 0, 0);
        vecs[6]  = mk("\0331+\0334-=5-6=",   0, 0,     0,  0, 1, 1);
        vecs[7]  = mk("65535-0=",            1, 65535, 0,  1, 0, 0);
        vecs[8]  = mk("1+99999=",            0, 0,     0,  0, 1, 2);
        vecs[9]  = mk("1+2+3=",              0, 0,     0,  0, 1, 1);
        vecs[10] = mk("0065535/00=",         1, 65535, 0,  3, 0, 0);
        pool = '{8'h30, 8'h35, 8'h39, 8'h2B, 8'h2D, 8'h2A, 8'h2F, 8'h3D,
                 8'h0D, 8'h20, 8'h1B, 8'h78};

        // Reset state
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst cmd_valid", cmd_valid, 0);
        check("rst err", err, 0);
        check("rst err_code", err_code, 0);
        check("rst operand_a", operand_a, 0);
        check("rst operand_b", operand_b, 0);
        check("rst opcode", opcode, 0);
        check("rst echo_valid", echo_valid, 0);
        check("rst echo_data", echo_data, 0);
        @(posedge clk);
        #1;

        // Table vectors
        for (int i = 0; i < 11; i++) begin
            got_cmd.delete();
            got_err.delete();
            send_str(vecs[i].s, (i == 0) ? 3 : 0);
            idle(4);
            check($sformatf("v%0d ncmd", i), got_cmd.size(), vecs[i].n_cmd);
            if (vecs[i].n_cmd > 0 && got_cmd.size() > 0) begin
                check($sformatf("v%0d a", i), got_cmd[$].a, vecs[i].a);
                check($sformatf("v%0d b", i), got_cmd[$].b, vecs[i].b);
                check($sformatf("v%0d op", i), got_cmd[$].op, vecs[i].op);
            end
            check($sformatf("v%0d nerr", i), got_err.size(), vecs[i].n_err);
            if (vecs[i].n_err > 0 && got_err.size() > 0) begin
                check($sformatf("v%0d err pulse code", i), got_err[$], vecs[i].code);
                check($sformatf("v%0d err_code held", i), err_code, vecs[i].code);
            end
        end

        // Back-pressure, latency and busy byte
        got_cmd.delete();
        got_err.delete();
        cmd_ready = 1'b0;
        send_str("65535*2", 2);
        rx_data  = 8'h0D;
        rx_valid = 1'b1;
        @(negedge clk);
        check("pre-term cmd_valid", cmd_valid, 0);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        @(negedge clk);
        check("term latency cmd_valid", cmd_valid, 1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hold%0d cmd_valid", k), cmd_valid, 1);
            check($sformatf("hold%0d a", k), operand_a, 65535);
            check($sformatf("hold%0d b", k), operand_b, 2);
            check($sformatf("hold%0d op", k), opcode, 2);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rx_data  = 8'h35;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        @(negedge clk);
        check("busy err", err, 1);
        check("busy err_code", err_code, 3);
        check("busy a kept", operand_a, 65535);
        check("busy b kept", operand_b, 2);
        check("busy cmd_valid kept", cmd_valid, 1);
`ifdef UART_ECHO_EN
        check("busy echo_valid", echo_valid, 1);
        check("busy echo_data", echo_data, 8'h35);
`endif
        @(negedge clk);
        check("busy err one cycle", err, 0);
        check("busy echo one cycle", echo_valid, 0);
        @(posedge clk);
        #1;
        cmd_ready = 1'b1;
        @(negedge clk);
        check("ready raised cmd_valid", cmd_valid, 1);
        @(negedge clk);
        check("after handshake cmd_valid", cmd_valid, 0);
        check("bp ncmd", got_cmd.size(), 1);
        if (got_cmd.size() > 0) check("bp cmd", got_cmd[0], {16'd65535, 16'd2, 2'd2});
        check("bp nerr", got_err.size(), 1);
        @(posedge clk);
        #1;

        // Reset mid-command
        got_cmd.delete();
        got_err.delete();
        send_str("12+3", 0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst cmd_valid", cmd_valid, 0);
        check("midrst err", err, 0);
        check("midrst a", operand_a, 0);
        check("midrst b", operand_b, 0);
        check("midrst err_code", err_code, 0);
        @(posedge clk);
        #1;
        idle(3);
        check("midrst ncmd", got_cmd.size(), 0);
        check("midrst nerr", got_err.size(), 0);
        send_str("1+1=", 0);
        idle(4);
        check("post-rst ncmd", got_cmd.size(), 1);
        if (got_cmd.size() > 0) check("post-rst cmd", got_cmd[0], {16'd1, 16'd1, 2'd0});
        check("post-rst nerr", got_err.size(), 0);

        // Random traffic against the reference model
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        got_cmd.delete();
        got_err.delete();
        exp_cmd.delete();
        exp_err.delete();
        model_clear();
        m_op = 2'd0;
        for (int n = 0; n < 200; n++) begin
            string s;
            if ($urandom_range(0, 1) == 0) begin
                int na, nb;
                logic [7:0] opch, tch;
                na   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60000, 70000))
                                                   : int'($urandom_range(0, 999));
                nb   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60000, 70000))
                                                   : int'($urandom_range(0, 999));
                opch = pool[3 + $urandom_range(0, 3)];
                tch  = ($urandom_range(0, 1) == 0) ? 8'h3D : 8'h0D;
                s    = $sformatf("%0d%c%0d%c", na, opch, nb, tch);
            end else begin
                s = $sformatf("%c", pool[$urandom_range(0, 11)]);
            end
            for (int j = 0; j < s.len(); j++) begin
                model_byte(s[j]);
                send_byte(s[j], int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
            end
        end
        idle(5);
        check("rand ncmd", got_cmd.size(), exp_cmd.size());
        check("rand nerr", got_err.size(), exp_err.size());
        for (int i = 0; i < exp_cmd.size() && i < got_cmd.size(); i++)
            check($sformatf("rand cmd%0d", i), got_cmd[i], exp_cmd[i]);
        for (int i = 0; i < exp_err.size() && i < got_err.size(); i++)
            check($sformatf("rand err%0d", i), got_err[i], exp_err[i]);

        check("err single-cycle pulses", pulse_bad, 0);
        check("operands stable while pending", stab_bad, 0);
`ifndef UART_ECHO_EN
        check("echo outputs idle", echo_bad, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
